// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core: FSM-sequenced datapath sharing one req/ready memory port
// for instruction fetch and data access.
module multi_cycle_cpu #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_UNKNOWN = 1'b1,
  parameter logic [31:0] ADDR_MASK       = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc_out,
  output logic [31:0] instruction,
  output logic [2:0]  state,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2,
    S_MEMORY = 3'd3, S_WRITEBACK = 3'd4, S_HALT = 3'd5
  } state_t;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_LUI = 6'h0F,
                         OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22,
                         FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

  state_t      state_reg;
  logic [31:0] pc_reg, ir_reg, mdr_reg, a_reg, b_reg, alu_out_reg, target_reg;
  logic        mem_req_reg, mem_we_reg, halted_reg;
  logic [31:0] mem_addr_reg, mem_wdata_reg;
  logic [31:0] rf [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] sext, jump_target, alu_result, fetch_pc, rf_wdata;
  logic        is_known, branch_taken, rf_we;
  logic [4:0]  rf_waddr;

  assign opcode      = ir_reg[31:26];
  assign rs          = ir_reg[25:21];
  assign rt          = ir_reg[20:16];
  assign rd          = ir_reg[15:11];
  assign shamt       = ir_reg[10:6];
  assign funct       = ir_reg[5:0];
  assign imm         = ir_reg[15:0];
  assign sext        = {{16{imm[15]}}, imm};
  assign jump_target = {pc_reg[31:28], ir_reg[25:0], 2'b00};
  assign branch_taken = ((opcode == OP_BEQ) && (a_reg == b_reg)) ||
                        ((opcode == OP_BNE) && (a_reg != b_reg));

  always_comb begin
    is_known = 1'b0;
    case (opcode)
      OP_R: begin
        case (funct)
          FN_SLL, FN_JR, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: is_known = 1'b1;
          default: is_known = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_LUI, OP_LW, OP_SW: is_known = 1'b1;
      default: is_known = 1'b0;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (opcode)
      OP_R: begin
        case (funct)
          FN_ADD:  alu_result = a_reg + b_reg;
          FN_SUB:  alu_result = a_reg - b_reg;
          FN_AND:  alu_result = a_reg & b_reg;
          FN_OR:   alu_result = a_reg | b_reg;
          FN_SLT:  alu_result = {31'd0, $signed(a_reg) < $signed(b_reg)};
          FN_SLL:  alu_result = b_reg << shamt;
          default: alu_result = '0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_result = a_reg + sext;
      OP_LUI:                alu_result = {imm, 16'h0000};
      default:               alu_result = '0;
    endcase
  end

  // Address of the next fetch; only EXECUTE of a control-flow instruction redirects it.
  always_comb begin
    fetch_pc = pc_reg;
    if (state_reg == S_EXECUTE) begin
      case (opcode)
        OP_BEQ, OP_BNE: if (branch_taken) fetch_pc = target_reg;
        OP_J, OP_JAL:   fetch_pc = jump_target;
        OP_R:           if (funct == FN_JR) fetch_pc = a_reg;
        default:        fetch_pc = pc_reg;
      endcase
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = '0;
    if ((state_reg == S_EXECUTE) && (opcode == OP_JAL)) begin
      rf_we    = 1'b1;
      rf_waddr = 5'd31;
      rf_wdata = pc_reg;
    end else if (state_reg == S_WRITEBACK) begin
      rf_we    = 1'b1;
      rf_waddr = (opcode == OP_R) ? rd : rt;
      rf_wdata = (opcode == OP_LW) ? mdr_reg : alu_out_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_FETCH;
      pc_reg        <= RESET_PC;
      ir_reg        <= '0;
      mdr_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      alu_out_reg   <= '0;
      target_reg    <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      halted_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          // First cycle out of reset has no request pending yet; raise it here.
          if (!mem_req_reg) begin
            mem_req_reg  <= 1'b1;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= pc_reg & ADDR_MASK;
          end else if (mem_ready) begin
            ir_reg      <= mem_rdata;
            pc_reg      <= pc_reg + 32'd4;
            mem_req_reg <= 1'b0;
            state_reg   <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_reg      <= rf[rs];
          b_reg      <= rf[rt];
          target_reg <= pc_reg + (sext << 2);
          if (is_known) begin
            state_reg <= S_EXECUTE;
          end else if (HALT_ON_UNKNOWN) begin
            state_reg  <= S_HALT;
            halted_reg <= 1'b1;
          end else begin
            state_reg    <= S_FETCH;
            mem_req_reg  <= 1'b1;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= fetch_pc & ADDR_MASK;
          end
        end
        S_EXECUTE: begin
          alu_out_reg <= alu_result;
          if ((opcode == OP_LW) || (opcode == OP_SW)) begin
            state_reg     <= S_MEMORY;
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= (opcode == OP_SW);
            mem_addr_reg  <= alu_result & ADDR_MASK;
            mem_wdata_reg <= b_reg;
          end else if ((opcode == OP_ADDI) || (opcode == OP_LUI) ||
                       ((opcode == OP_R) && (funct != FN_JR))) begin
            state_reg <= S_WRITEBACK;
          end else begin
            pc_reg       <= fetch_pc;
            state_reg    <= S_FETCH;
            mem_req_reg  <= 1'b1;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= fetch_pc & ADDR_MASK;
          end
        end
        S_MEMORY: begin
          if (mem_req_reg && mem_ready) begin
            if (mem_we_reg) begin
              state_reg    <= S_FETCH;
              mem_we_reg   <= 1'b0;
              mem_addr_reg <= fetch_pc & ADDR_MASK;
            end else begin
              mdr_reg     <= mem_rdata;
              mem_req_reg <= 1'b0;
              state_reg   <= S_WRITEBACK;
            end
          end
        end
        S_WRITEBACK: begin
          state_reg    <= S_FETCH;
          mem_req_reg  <= 1'b1;
          mem_we_reg   <= 1'b0;
          mem_addr_reg <= fetch_pc & ADDR_MASK;
        end
        default: begin
          mem_req_reg <= 1'b0;
          halted_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign mem_req     = mem_req_reg;
  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign pc_out      = pc_reg;
  assign instruction = ir_reg;
  assign state       = state_reg;
  assign halted      = halted_reg;

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Scoreboard bench for multi_cycle_cpu: directed programs, expected bus transactions
// queued up front and checked by a monitor that also acts as the wait-state memory.
module tb_multi_cycle_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out, instruction;
  logic [2:0]  state;

  always #5 clk = ~clk;

  multi_cycle_cpu #(
    .RESET_PC(32'h0000_0100),
    .HALT_ON_UNKNOWN(1'b1),
    .ADDR_MASK(32'hFFFF_FFFF)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc_out(pc_out), .instruction(instruction), .state(state), .halted(halted)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  int          exp_lat [logic [31:0]];
  logic [31:0] mem [0:1023];
  int          n_run = 0;
  int          n_fail = 0;
  int          wait_states = 0;
  bit          stall_writes = 1'b0;
  int          wait_cnt = 0;
  int          lat_cnt = 0;
  logic [2:0]  prev_state = 3'd0;

  function automatic logic [31:0] i_op(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] r_op(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [4:0] sh, logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] j_op(logic [5:0] op, logic [25:0] t);
    return {op, t};
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic put(logic [31:0] addr, logic [31:0] word);
    mem[addr[11:2]] = word;
  endtask
  task automatic push_f(logic [31:0] a);
    exp_q.push_back('{we: 1'b0, addr: a, data: 32'h0});
  endtask
  task automatic push_r(logic [31:0] a);
    exp_q.push_back('{we: 1'b0, addr: a, data: 32'h0});
  endtask
  task automatic push_w(logic [31:0] a, logic [31:0] d);
    exp_q.push_back('{we: 1'b1, addr: a, data: d});
  endtask

  // Reset the core mid-cycle, clear memory and latency table, hold reset two cycles.
  task automatic begin_phase(int ws, bit stall);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    exp_lat.delete();
    wait_states  = ws;
    stall_writes = stall;
  endtask
  task automatic release_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic wait_drained(string name, int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    fork
      // Monitor + memory: decides mem_ready for the coming edge and scores each completed access.
      forever begin
        @(negedge clk);
        if (mem_ready) wait_cnt = 0;
        mem_ready = 1'b0;
        if (!rst) begin
          wait_cnt   = 0;
          lat_cnt    = 0;
          prev_state = 3'd0;
        end else begin
          if (state == 3'd0 && prev_state != 3'd0) begin
            if (exp_lat.exists(instruction))
              chk("latency", lat_cnt, exp_lat[instruction]);
            lat_cnt = 1;
          end else begin
            lat_cnt++;
          end
          prev_state = state;
          if (mem_req) begin
            if (wait_cnt >= wait_states && !(stall_writes && mem_we)) begin
              mem_ready = 1'b1;
              mem_rdata = mem[mem_addr[11:2]];
              $display("[TB] bus we=%0b addr=%h wdata=%h rdata=%h", mem_we, mem_addr, mem_wdata, mem_rdata);
              if (exp_q.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL unexpected_access: got we=%0b addr=%h, expected no access", mem_we, mem_addr);
              end else begin
                txn_t e;
                e = exp_q.pop_front();
                chk("bus_we", {31'd0, mem_we}, {31'd0, e.we});
                chk("bus_addr", mem_addr, e.addr);
                if (e.we) chk("bus_wdata", mem_wdata, e.data);
              end
              if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
            end else begin
              wait_cnt++;
            end
          end else begin
            wait_cnt = 0;
          end
        end
      end

      begin
        // ---- Phase 1: reset, handshake, ALU ops with 2 wait states, illegal opcode ----
        begin_phase(2, 1'b0);
        put(32'h100, i_op(6'h08, 5'd0, 5'd1, 16'd5));
        put(32'h104, i_op(6'h08, 5'd0, 5'd2, 16'hFFFD));
        put(32'h108, r_op(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
        put(32'h10C, r_op(5'd2, 5'd1, 5'd4, 5'd0, 6'h2A));
        put(32'h110, r_op(5'd1, 5'd2, 5'd7, 5'd0, 6'h22));
        put(32'h114, r_op(5'd1, 5'd2, 5'd8, 5'd0, 6'h24));
        put(32'h118, r_op(5'd1, 5'd2, 5'd9, 5'd0, 6'h25));
        put(32'h11C, r_op(5'd0, 5'd1, 5'd10, 5'd4, 6'h00));
        put(32'h120, i_op(6'h2B, 5'd0, 5'd3, 16'h0200));
        put(32'h124, i_op(6'h2B, 5'd0, 5'd4, 16'h0204));
        put(32'h128, i_op(6'h2B, 5'd0, 5'd7, 16'h0208));
        put(32'h12C, i_op(6'h2B, 5'd0, 5'd8, 16'h020C));
        put(32'h130, i_op(6'h2B, 5'd0, 5'd9, 16'h0210));
        put(32'h134, i_op(6'h2B, 5'd0, 5'd10, 16'h0214));
        put(32'h138, 32'hFC00_0000);
        exp_lat[r_op(5'd1, 5'd2, 5'd3, 5'd0, 6'h20)] = 6;
        exp_lat[i_op(6'h2B, 5'd0, 5'd3, 16'h0200)]   = 8;
        for (int i = 0; i < 8; i++) push_f(32'h100 + 4 * i);
        push_f(32'h120); push_w(32'h200, 32'h0000_0002);
        push_f(32'h124); push_w(32'h204, 32'h0000_0001);
        push_f(32'h128); push_w(32'h208, 32'h0000_0008);
        push_f(32'h12C); push_w(32'h20C, 32'h0000_0005);
        push_f(32'h130); push_w(32'h210, 32'hFFFF_FFFD);
        push_f(32'h134); push_w(32'h214, 32'h0000_0050);
        push_f(32'h138);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", pc_out, 32'h100);
        chk("reset_state", {29'd0, state}, 32'd0);
        chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset_ir", instruction, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("first_req", {31'd0, mem_req}, 32'd1);
        chk("first_addr", mem_addr, 32'h100);
        for (int i = 0; i < 1000 && !halted; i++) begin
          @(posedge clk);
          #1;
        end
        chk("halted", {31'd0, halted}, 32'd1);
        chk("halt_state", {29'd0, state}, 32'd5);
        chk("halt_mem_req", {31'd0, mem_req}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("halt_pc_frozen", pc_out, 32'h13C);
        chk("halt_mem_req_later", {31'd0, mem_req}, 32'd0);
        chk("phase1_drained", exp_q.size(), 0);

        // ---- Phase 2: zero wait: load/store, branches, jumps, lui, $0 ----
        begin_phase(0, 1'b0);
        put(32'h100, i_op(6'h08, 5'd0, 5'd1, 16'd5));
        put(32'h104, i_op(6'h2B, 5'd0, 5'd1, 16'h0008));
        put(32'h108, i_op(6'h23, 5'd0, 5'd5, 16'h0008));
        put(32'h10C, i_op(6'h2B, 5'd0, 5'd5, 16'h0208));
        put(32'h110, j_op(6'h02, 26'h0));
        put(32'h000, i_op(6'h04, 5'd1, 5'd1, 16'd2));
        put(32'h00C, i_op(6'h05, 5'd1, 5'd1, 16'd2));
        put(32'h010, j_op(6'h02, 26'h8));
        put(32'h020, j_op(6'h03, 26'h10));
        put(32'h040, i_op(6'h0F, 5'd0, 5'd6, 16'hABCD));
        put(32'h044, i_op(6'h08, 5'd0, 5'd0, 16'd7));
        put(32'h048, i_op(6'h2B, 5'd0, 5'd6, 16'h020C));
        put(32'h04C, i_op(6'h2B, 5'd0, 5'd0, 16'h0210));
        put(32'h050, i_op(6'h2B, 5'd0, 5'd31, 16'h0214));
        put(32'h054, r_op(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));
        put(32'h024, i_op(6'h04, 5'd0, 5'd0, 16'hFFFF));
        exp_lat[i_op(6'h2B, 5'd0, 5'd1, 16'h0008)]  = 4;
        exp_lat[i_op(6'h23, 5'd0, 5'd5, 16'h0008)]  = 5;
        exp_lat[i_op(6'h04, 5'd1, 5'd1, 16'd2)]     = 3;
        exp_lat[i_op(6'h05, 5'd1, 5'd1, 16'd2)]     = 3;
        exp_lat[j_op(6'h02, 26'h8)]                 = 3;
        exp_lat[j_op(6'h03, 26'h10)]                = 3;
        exp_lat[i_op(6'h0F, 5'd0, 5'd6, 16'hABCD)]  = 4;
        exp_lat[r_op(5'd31, 5'd0, 5'd0, 5'd0, 6'h08)] = 3;
        push_f(32'h100); push_f(32'h104); push_w(32'h008, 32'h5);
        push_f(32'h108); push_r(32'h008);
        push_f(32'h10C); push_w(32'h208, 32'h5);
        push_f(32'h110); push_f(32'h000); push_f(32'h00C); push_f(32'h010);
        push_f(32'h020); push_f(32'h040); push_f(32'h044);
        push_f(32'h048); push_w(32'h20C, 32'hABCD_0000);
        push_f(32'h04C); push_w(32'h210, 32'h0);
        push_f(32'h050); push_w(32'h214, 32'h24);
        push_f(32'h054); push_f(32'h024); push_f(32'h024); push_f(32'h024);
        release_reset();
        wait_drained("phase2_drained", 2000);

        // ---- Phase 3: stalled store, then reset during the stall ----
        begin_phase(0, 1'b1);
        put(32'h100, i_op(6'h08, 5'd0, 5'd1, 16'd9));
        put(32'h104, i_op(6'h2B, 5'd0, 5'd1, 16'h0300));
        push_f(32'h100); push_f(32'h104);
        release_reset();
        for (int i = 0; i < 200 && state != 3'd3; i++) begin
          @(posedge clk);
          #1;
        end
        chk("stall_state", {29'd0, state}, 32'd3);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_req", {31'd0, mem_req}, 32'd1);
        chk("stall_we", {31'd0, mem_we}, 32'd1);
        chk("stall_addr", mem_addr, 32'h300);
        chk("stall_wdata", mem_wdata, 32'd9);
        #2 rst = 1'b0;
        #1;
        chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
        chk("abort_pc", pc_out, 32'h100);
        chk("abort_state", {29'd0, state}, 32'd0);
        chk("phase3_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
      end
    join
  end

endmodule
